// File: rtl/mips_mmio_pkg.sv
// ============================================================================
// Module  : mips_mmio_pkg
// Brief   : Register offsets, STATUS bit positions and default window base
//           shared by the MMIO output port and its FIFO.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mips_mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

  // Word offsets within the window, taken from address[3:2]
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_HALT   = 2'd2;
  localparam logic [1:0] OFF_COUNT  = 2'd3;

  // STATUS flag positions, relative to bit CNT_W of the status word
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_HALT  = 2;
  localparam int ST_OVF   = 3;

endpackage

`default_nettype wire

// File: rtl/mips_mmio_fifo.sv
// ============================================================================
// Module  : mips_mmio_fifo
// Brief   : 32-bit synchronous FIFO with show-ahead head word, asynchronous
//           active-high reset and occupancy count.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mips_mmio_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  // One extra bit beyond the address lets wr-rd distinguish full from empty
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/mips_mmio_out_port.sv
// ============================================================================
// Module  : mips_mmio_out_port
// Brief   : MMIO output responder: DATA push FIFO, STATUS, sticky HALT and
//           overflow. Define MIPS_MMIO_OUT_COUNT_EN for the delivered-word
//           counter at +0xC.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mips_mmio_out_port
  import mips_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          DEPTH     = 4,
  parameter int          CNT_W     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mmio_hit,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        halt
);

  logic [1:0]       offset;
  logic             wr_hit;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             ovf_set;
  logic             ovf_clr;
  logic [31:0]      status_word;
  logic [31:0]      delivered;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = &{1'b0, address[1:0]};

  assign mmio_hit  = (address[31:4] == BASE_ADDR[31:4]);
  assign offset    = address[3:2];
  assign wr_hit    = mem_write && mmio_hit;
  assign push      = wr_hit && (offset == OFF_DATA);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign ovf_set   = push && full && !pop;
  assign ovf_clr   = wr_hit && (offset == OFF_STATUS) && write_data[0];

  mips_mmio_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (write_data),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halt     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_hit && (offset == OFF_HALT)) halt <= 1'b1;
      // A new overflow outranks a same-cycle clear
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef MIPS_MMIO_OUT_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      delivered <= 32'd0;
    end else if (wr_hit && (offset == OFF_COUNT)) begin
      delivered <= 32'd0;
    end else if (pop) begin
      delivered <= delivered + 32'd1;
    end
  end
`else
  assign delivered = 32'd0;
`endif

  always_comb begin
    status_word                  = 32'd0;
    status_word[CNT_W-1:0]       = count;
    status_word[CNT_W+ST_EMPTY]  = empty;
    status_word[CNT_W+ST_FULL]   = full;
    status_word[CNT_W+ST_HALT]   = halt;
    status_word[CNT_W+ST_OVF]    = overflow;
  end

  always_comb begin
    read_data = 32'd0;
    if (mem_read && mmio_hit) begin
      case (offset)
        OFF_STATUS: read_data = status_word;
        OFF_COUNT:  read_data = delivered;
        default:    read_data = 32'd0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_mmio_out_port.sv
// ============================================================================
// Module  : tb_mips_mmio_out_port
// Brief   : Directed and random bench for mips_mmio_out_port against a
//           queue-based reference model; honours MIPS_MMIO_OUT_COUNT_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_mmio_out_port;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          DEP  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        mmio_hit;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        halt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q[$];
  logic        m_halt;
  logic        m_ovf;
  logic [31:0] m_cnt;

  mips_mmio_out_port dut (
    .clock      (clock),
    .reset      (reset),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .mmio_hit   (mmio_hit),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .halt       (halt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic re, input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (re && a[31:4] == BASE[31:4]) begin
      if (a[3:2] == 2'd1) begin
        v = q.size() + 8 * (q.size() == 0) + 16 * (q.size() == DEP)
            + 32 * m_halt + 64 * m_ovf;
      end else if (a[3:2] == 2'd3) begin
`ifdef MIPS_MMIO_OUT_COUNT_EN
        v = m_cnt;
`else
        v = 32'd0;
`endif
      end
    end
    return v;
  endfunction

  task automatic model_clear();
    q.delete();
    m_halt = 1'b0;
    m_ovf  = 1'b0;
    m_cnt  = 32'd0;
  endtask

  // One bus cycle: drive, check outputs against the model, advance the model
  task automatic cyc(input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] wd, input logic rdy);
    logic hit, do_pop, do_push, ovf_set, ovf_clr;
    @(negedge clock);
    mem_write  = we;
    mem_read   = re;
    address    = a;
    write_data = wd;
    out_ready  = rdy;
    #1;
    hit = (a[31:4] == BASE[31:4]);
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    check("out_data", out_data, (q.size() != 0) ? q[0] : 32'd0);
    check("halt", {31'd0, halt}, {31'd0, m_halt});
    check("mmio_hit", {31'd0, mmio_hit}, {31'd0, hit});
    check("read_data", read_data, exp_read(re, a));
    do_pop  = rdy && (q.size() != 0);
    do_push = we && hit && (a[3:2] == 2'd0);
    ovf_set = do_push && (q.size() == DEP) && !do_pop;
    ovf_clr = we && hit && (a[3:2] == 2'd1) && wd[0];
    if (do_pop) void'(q.pop_front());
    if (do_push && !ovf_set) q.push_back(wd);
    if (ovf_set) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (we && hit && a[3:2] == 2'd2) m_halt = 1'b1;
    if (we && hit && a[3:2] == 2'd3) m_cnt = 32'd0;
    else if (do_pop) m_cnt = m_cnt + 32'd1;
    @(posedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    mem_write = 1'b0;
    mem_read  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    model_clear();
    @(negedge clock);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    model_clear();
    do_reset();

    // Reset status
    cyc(0, 1, BASE + 32'h4, 32'd0, 0);

    // Single word held while not ready, then popped
    cyc(1, 0, BASE, 32'hDEADBEEF, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, BASE + 32'h4, 32'd0, 0);
    cyc(0, 0, BASE, 32'd0, 1);
    cyc(0, 1, BASE + 32'h4, 32'd0, 0);

    // Overflow, ordered drain, overflow clear
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1, 0, BASE, i, 0);
    cyc(0, 1, BASE + 32'h4, 32'd0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, BASE, 32'd0, 1);
    cyc(1, 0, BASE + 32'h4, 32'd1, 0);
    cyc(0, 1, BASE + 32'h4, 32'd0, 0);

    // Push and pop on a full FIFO
    for (int i = 1; i <= 4; i++) cyc(1, 0, BASE, i, 0);
    cyc(1, 0, BASE, 32'd9, 1);
    cyc(0, 1, BASE + 32'h4, 32'd0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, BASE, 32'd0, 1);

    // Sticky halt, then asynchronous reset mid-cycle
    cyc(1, 0, BASE + 32'h8, 32'd0, 0);
    cyc(1, 0, BASE, 32'h1234, 0);
    cyc(0, 1, BASE + 32'h4, 32'd0, 0);
    @(negedge clock);
    mem_write = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_clear();
    check("async_halt", {31'd0, halt}, 32'd0);
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Delivered-word counter
    for (int i = 0; i < 6; i++) cyc(1, 0, BASE, 32'h100 + i, 1);
    cyc(0, 0, BASE, 32'd0, 1);
    cyc(0, 1, BASE + 32'hC, 32'd0, 0);
    cyc(1, 0, BASE + 32'hC, 32'd0, 0);
    cyc(0, 1, BASE + 32'hC, 32'd0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE | {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 40) != 0 && a[3:2] == 2'd2) a[3:2] = 2'd0;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
          1'($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
